uart_line_receiver: RTL and testbench
=====================================

# uart_line_receiver

Standalone far-end serial receiver for the UART link. It deserializes the frames that the transmitter drives onto the serial line, using the same `baud_rate` and `parity_type` encodings. It adds 16x oversampling, frame error classification and a small receive FIFO with a valid/ready read port. The block sits at the remote end of the line, between the serial pin and the consuming logic.

## Interface
- `CLOCK_HZ`, 50_000_000, system clock frequency in Hz.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of 2, range 2–16.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_rx`  in  1  serial line; idle high; asynchronous to `clock`.
- `baud_rate`  in  2  baud select: 00=2400, 01=4800, 10=9600, 11=19200.
- `parity_type`  in  2  parity select: 00=none, 01=odd, 10=even, 11=none.
- `ready`  in  1  consumer accepts the head entry.
- `valid`  out  1  FIFO non-empty; head entry is presented.
- `data_out`  out  8  head entry data byte.
- `error_flag`  out  3  head entry flags: [0] parity error, [1] break, [2] stop error.
- `overrun_flag`  out  1  sticky; at least one frame was dropped because the FIFO was full.
- `active_flag`  out  1  high while a frame is being received (state ≠ IDLE).

## Operation
- Input conditioning: `data_rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Oversample tick generator:
  - DIV = CLOCK_HZ / (16 × baud), integer truncation.
  - The counter counts 0..DIV-1 and pulses `tick` at DIV-1.
  - The counter restarts at 0 on start-edge detection.
- Bit timing: a 4-bit sub-bit counter counts ticks 0..15 within each bit. The bit sample is taken at sub-bit count 8.
- `baud_rate` and `parity_type` are latched on start-edge detection. Changes during a frame take effect at the next frame.
- State machine:
  - ARM: entered from reset. Waits until the synchronized line is high for 16 consecutive ticks, then goes to IDLE.
  - IDLE: a synchronized falling edge (1→0) goes to START.
  - START: at the sample point, a low line goes to DATA. A high line is a glitch: go to IDLE, nothing is pushed.
  - DATA: 8 samples, LSB first, shifted into the data register. After bit 7, go to PARITY if parity is enabled, else to STOP.
  - PARITY: one sample is compared against the computed parity. Odd parity means data plus parity bit has an odd number of ones.
  - STOP: one sample is taken, the entry is pushed, then go to IDLE.
- Error flags per entry:
  - stop error = stop sample is 0.
  - break = all 8 data bits are 0, the stop sample is 0, and the parity bit (if enabled) is 0.
  - parity error = parity enabled and mismatch. Always 0 when parity is disabled.
- FIFO:
  - Show-ahead; each entry is {error_flag, data}.
  - Pop occurs on `valid && ready`.
  - Push occurs at the STOP sample.
  - Push while full, with no pop in the same cycle: the frame is dropped and `overrun_flag` is set.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Read and write pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
- `overrun_flag` clears on the next pop, or on reset.

## Timing
- Reset values:
  - All outputs 0: `valid`, `data_out`, `error_flag`, `overrun_flag`, `active_flag`.
  - State = ARM, FIFO empty, counters 0.
- Input latency: 2 clocks of synchronizer delay, plus 1 clock for edge detection.
- Output latency:
  - The entry is written at the clock edge that processes the stop sample tick.
  - `valid` is high on the following cycle.
  - `data_out`/`error_flag` are stable while `valid && !ready`.
- `active_flag` rises the cycle after edge detection and falls the cycle after the push.
- Reset mid-frame: the partial frame is discarded, the FIFO is emptied, and the block re-enters ARM. A line that is low after reset is not mistaken for a start bit.
- Frame duration is 16 × (10 + parity_enabled) ticks.

## Configuration
- `UART_RX_MAJORITY_EN`
  - Defined: each bit sample is the 2-of-3 majority of the line at sub-bit counts 7, 8 and 9. The decision is made at count 9. The START glitch check uses the same majority.
  - Undefined: a single sample at count 8.
  - The state sequence and push timing are identical in both builds, apart from the sample instant.

## Test plan
- 9600 baud, even parity, send 0xA5 with correct parity → one entry: `data_out`=0xA5, `error_flag`=000, `valid` held until `ready`.
- 19200 baud, odd parity, 0x3C sent with a wrong parity bit → `data_out`=0x3C, `error_flag`=001.
- 2400 baud, no parity, line held low for 12 bit times → entry with `data_out`=0x00, `error_flag`=110. No second entry until the line is high and a new falling edge occurs.
- `FIFO_DEPTH`=4, `ready`=0, five frames 0x01..0x05 → `valid`=1, `overrun_flag`=1 after the fifth frame. Pops return 0x01..0x04. `overrun_flag` clears on the first pop.
- Low pulse of 3 ticks on an idle line → no push, `active_flag` falls after the START sample. With `UART_RX_MAJORITY_EN`, a 1-tick low spike at count 8 inside a data bit of 0xFF → data_out=0xFF.
- Assert `reset` at data bit 4 while the line is low → all outputs 0 and FIFO empty. The next frame (0x5A), received after ≥16 idle ticks, arrives intact.

Source files
------------

// File: rtl/uart_line_receiver.sv
// Far-end UART receiver: 16x oversampling, per-frame error flags, show-ahead receive FIFO.
// Build macro UART_RX_MAJORITY_EN switches bit sampling to a 2-of-3 majority vote.
module uart_line_receiver #(
    parameter int unsigned CLOCK_HZ   = 50_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data_out,
    output logic [2:0] error_flag,
    output logic       overrun_flag,
    output logic       active_flag
);
    localparam int unsigned Div2400  = CLOCK_HZ / (16 * 2400);
    localparam int unsigned Div4800  = CLOCK_HZ / (16 * 4800);
    localparam int unsigned Div9600  = CLOCK_HZ / (16 * 9600);
    localparam int unsigned Div19200 = CLOCK_HZ / (16 * 19200);
    localparam int unsigned CntW     = (Div2400 > 1) ? $clog2(Div2400) : 1;
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW   = PtrW + 1;

    typedef enum logic [2:0] {StArm, StIdle, StStart, StData, StParity, StStop} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_line_prev;
    logic              w_fall;
    logic              w_start;
    logic [1:0]        w_baud_sel;
    logic [CntW-1:0]   w_div_max;
    logic [CntW-1:0]   r_div_cnt;
    logic              w_tick;
    logic [3:0]        r_sub;
    logic              w_sample_pt;
    logic              w_bit;
    logic              w_push;
    logic [1:0]        r_baud;
    logic              r_par_en;
    logic              r_par_odd;
    logic [7:0]        r_shift;
    logic [2:0]        r_bitcnt;
    logic              r_par_bit;
    logic              r_par_err;
    logic              w_par_exp;
    logic              w_break;
    logic [10:0]       w_entry;
    logic [10:0]       r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CountW-1:0] r_count;
    logic              r_overrun;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic [10:0]       w_head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
        end else begin
            r_sync1     <= data_rx;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    assign w_fall  = r_line_prev & ~r_sync2;
    assign w_start = (r_state == StIdle) && w_fall;

    // Between frames the divider follows the live select; inside a frame it uses the latched one.
    assign w_baud_sel = (r_state == StArm || r_state == StIdle) ? baud_rate : r_baud;

    always_comb begin
        w_div_max = CntW'(Div2400 - 1);
        case (w_baud_sel)
            2'b00:   w_div_max = CntW'(Div2400 - 1);
            2'b01:   w_div_max = CntW'(Div4800 - 1);
            2'b10:   w_div_max = CntW'(Div9600 - 1);
            default: w_div_max = CntW'(Div19200 - 1);
        endcase
    end

    assign w_tick = (r_div_cnt >= w_div_max);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_sub     <= '0;
        end else begin
            if (w_start || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + CntW'(1);
            end
            // In ARM the sub-bit counter measures consecutive high ticks.
            if (w_start || (r_state == StArm && !r_sync2)) begin
                r_sub <= '0;
            end else if (w_tick) begin
                r_sub <= r_sub + 4'd1;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_maj <= 2'b11;
        end else if (w_tick && r_sub == 4'd7) begin
            r_maj[0] <= r_sync2;
        end else if (w_tick && r_sub == 4'd8) begin
            r_maj[1] <= r_sync2;
        end
    end

    assign w_sample_pt = w_tick && (r_sub == 4'd9);
    assign w_bit       = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_sync2) | (r_maj[1] & r_sync2);
`else
    assign w_sample_pt = w_tick && (r_sub == 4'd8);
    assign w_bit       = r_sync2;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StArm;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            StArm: begin
                if (w_tick && r_sync2 && r_sub == 4'd15) w_state_next = StIdle;
            end
            StIdle: begin
                if (w_fall) w_state_next = StStart;
            end
            StStart: begin
                if (w_sample_pt) w_state_next = w_bit ? StIdle : StData;
            end
            StData: begin
                if (w_sample_pt && r_bitcnt == 3'd7) begin
                    w_state_next = r_par_en ? StParity : StStop;
                end
            end
            StParity: begin
                if (w_sample_pt) w_state_next = StStop;
            end
            StStop: begin
                if (w_sample_pt) begin
                    w_state_next = StIdle;
                    w_push       = 1'b1;
                end
            end
            default: w_state_next = StArm;
        endcase
    end

    assign w_par_exp = r_par_odd ? ~^r_shift : ^r_shift;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_baud    <= 2'b00;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else if (w_start) begin
            r_baud    <= baud_rate;
            r_par_en  <= (parity_type == 2'b01) || (parity_type == 2'b10);
            r_par_odd <= (parity_type == 2'b01);
            r_bitcnt  <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else if (w_sample_pt && r_state == StData) begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
        end else if (w_sample_pt && r_state == StParity) begin
            r_par_bit <= w_bit;
            r_par_err <= (w_bit != w_par_exp);
        end
    end

    assign w_break = (r_shift == 8'h00) && !w_bit && !(r_par_en && r_par_bit);
    assign w_entry = {!w_bit, w_break, r_par_err, r_shift};

    assign valid   = (r_count != '0);
    assign w_full  = (r_count == CountW'(FIFO_DEPTH));
    assign w_pop   = valid && ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PtrW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CountW'(1);
                2'b01:   r_count <= r_count - CountW'(1);
                default: ;
            endcase
            if (w_pop) begin
                r_overrun <= 1'b0;
            end else if (w_push && w_full) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign data_out     = valid ? w_head[7:0] : 8'h00;
    assign error_flag   = valid ? w_head[10:8] : 3'b000;
    assign overrun_flag = r_overrun;
    assign active_flag  = (r_state != StArm) && (r_state != StIdle);

endmodule

// File: tb/tb_uart_line_receiver.sv
// Scoreboard bench for uart_line_receiver: frames are modelled when driven, checked when popped.
module tb_uart_line_receiver;
    localparam int unsigned ClockHz = 1_228_800;
    localparam int unsigned Depth   = 4;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       data_rx     = 1'b1;
    logic [1:0] baud_rate   = 2'b10;
    logic [1:0] parity_type = 2'b00;
    logic       ready       = 1'b0;
    logic       valid;
    logic [7:0] data_out;
    logic [2:0] error_flag;
    logic       overrun_flag;
    logic       active_flag;

    always #5 clock = ~clock;

    uart_line_receiver #(
        .CLOCK_HZ  (ClockHz),
        .FIFO_DEPTH(Depth)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_rx     (data_rx),
        .baud_rate   (baud_rate),
        .parity_type (parity_type),
        .ready       (ready),
        .valid       (valid),
        .data_out    (data_out),
        .error_flag  (error_flag),
        .overrun_flag(overrun_flag),
        .active_flag (active_flag)
    );

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] data;
    } entry_t;

    entry_t      sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned div_of(input logic [1:0] br);
        case (br)
            2'b00:   return ClockHz / (16 * 2400);
            2'b01:   return ClockHz / (16 * 4800);
            2'b10:   return ClockHz / (16 * 9600);
            default: return ClockHz / (16 * 19200);
        endcase
    endfunction

    function automatic entry_t model_entry(input logic [7:0] d, input logic [1:0] pt,
                                           input bit bad_par, input bit stop_v);
        entry_t e;
        bit     par_en;
        logic   pbit;
        par_en = (pt == 2'b01) || (pt == 2'b10);
        pbit   = ((pt == 2'b01) ? ~^d : ^d) ^ bad_par;
        e.data = d;
        e.err  = {!stop_v, (d == 8'h00) && !stop_v && !(par_en && pbit), par_en && bad_par};
        return e;
    endfunction

    // Inputs change 1 time unit after a rising edge.
    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_slot(input logic v, input int unsigned n);
        data_rx = v;
        step(n);
    endtask

    // spike_bit >= 0 puts a one-tick low pulse over the sample instant of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] br, input logic [1:0] pt,
                              input bit bad_par, input bit stop_v, input int spike_bit,
                              input bit expect_push);
        int unsigned div;
        bit          par_en;
        logic        pbit;
        logic [7:0]  rx_d;
        div    = div_of(br);
        par_en = (pt == 2'b01) || (pt == 2'b10);
        pbit   = ((pt == 2'b01) ? ~^d : ^d) ^ bad_par;
        rx_d   = d;
`ifndef UART_RX_MAJORITY_EN
        if (spike_bit >= 0) rx_d[spike_bit] = 1'b0;
`endif
        if (expect_push) sb.push_back(model_entry(rx_d, pt, bad_par, stop_v));
        baud_rate   = br;
        parity_type = pt;
        drive_slot(1'b0, 16 * div);
        baud_rate   = ~br;
        parity_type = pt ^ 2'b11;
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive_slot(1'b1, 8 * div + div / 2);
                drive_slot(1'b0, div);
                drive_slot(1'b1, 7 * div - div / 2);
            end else begin
                drive_slot(d[i], 16 * div);
            end
        end
        if (par_en) drive_slot(pbit, 16 * div);
        drive_slot(stop_v, 16 * div);
        baud_rate   = br;
        parity_type = pt;
        drive_slot(1'b1, 4 * div);
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
        ready = 1'b0;
        check_eq("drain_sb_empty", sb.size(), 0);
        step(2);
        check_eq("fifo_empty_after_drain", 32'(valid), 0);
    endtask

    always @(negedge clock) begin
        entry_t e;
        if (valid && ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pop", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("pop_data", 32'(data_out), 32'(e.data));
                check_eq("pop_err", 32'(error_flag), 32'(e.err));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(4);
        check_eq("rst_valid", 32'(valid), 0);
        check_eq("rst_data", 32'(data_out), 0);
        check_eq("rst_err", 32'(error_flag), 0);
        check_eq("rst_overrun", 32'(overrun_flag), 0);
        check_eq("rst_active", 32'(active_flag), 0);
        reset = 1'b0;
        step(20 * 16 * 8);
        check_eq("arm_active", 32'(active_flag), 0);

        // 9600 even, good parity; entry held until ready.
        send_frame(8'hA5, 2'b10, 2'b10, 1'b0, 1'b1, -1, 1'b1);
        step(40);
        check_eq("hold_valid", 32'(valid), 1);
        check_eq("hold_data", 32'(data_out), 32'h A5);
        check_eq("hold_err", 32'(error_flag), 0);
        drain();

        // 19200 odd with wrong parity; parity 11 with bad stop; 4800 even break.
        send_frame(8'h3C, 2'b11, 2'b01, 1'b1, 1'b1, -1, 1'b1);
        send_frame(8'h81, 2'b11, 2'b11, 1'b0, 1'b0, -1, 1'b1);
        send_frame(8'h00, 2'b01, 2'b10, 1'b0, 1'b0, -1, 1'b1);
        drain();

        // 2400, line low for 12 bit times: a single break entry.
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        sb.push_back(model_entry(8'h00, 2'b00, 1'b0, 1'b0));
        drive_slot(1'b0, 12 * 16 * 32);
        drive_slot(1'b1, 2 * 16 * 32);
        drain();

        // Overrun: five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 2'b11, 2'b00, 1'b0, 1'b1, -1, i <= Depth);
        end
        check_eq("ovr_flag_set", 32'(overrun_flag), 1);
        check_eq("ovr_valid", 32'(valid), 1);
        check_eq("ovr_head", 32'(data_out), 32'h01);
        ready = 1'b1;
        step(1);
        check_eq("ovr_flag_clr", 32'(overrun_flag), 0);
        drain();

        // 3-tick low glitch at 19200: no push, frame abandoned after the start sample.
        baud_rate = 2'b11;
        drive_slot(1'b0, 6);
        check_eq("glitch_active_hi", 32'(active_flag), 1);
        drive_slot(1'b0, 6);
        drive_slot(1'b1, 33);
        check_eq("glitch_active_lo", 32'(active_flag), 0);
        check_eq("glitch_no_push", 32'(valid), 0);

        // One-tick spike over the sample instant of data bit 3.
        send_frame(8'hFF, 2'b10, 2'b00, 1'b0, 1'b1, 3, 1'b1);
        drain();

        // Reset during data bit 4 with the line low and one entry queued.
        send_frame(8'h77, 2'b10, 2'b00, 1'b0, 1'b1, -1, 1'b1);
        baud_rate = 2'b10;
        drive_slot(1'b0, 16 * 8);
        for (int i = 0; i < 4; i++) drive_slot(((8'hE3 >> i) & 8'h01) != 0, 16 * 8);
        drive_slot(1'b0, 8 * 8);
        check_eq("pre_rst_active", 32'(active_flag), 1);
        check_eq("pre_rst_valid", 32'(valid), 1);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        sb.delete();
        check_eq("mid_rst_valid", 32'(valid), 0);
        check_eq("mid_rst_data", 32'(data_out), 0);
        check_eq("mid_rst_err", 32'(error_flag), 0);
        check_eq("mid_rst_overrun", 32'(overrun_flag), 0);
        check_eq("mid_rst_active", 32'(active_flag), 0);
        drive_slot(1'b0, 20 * 16 * 8);
        check_eq("low_after_rst_active", 32'(active_flag), 0);
        check_eq("low_after_rst_valid", 32'(valid), 0);
        drive_slot(1'b1, 24 * 16 * 8);
        send_frame(8'h5A, 2'b10, 2'b10, 1'b0, 1'b1, -1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
